// File: rtl/lc3_decode_pipe_if.sv
// lc3_decode_pipe_if: fetch-side and execute-side handshake bundle.
// Optional illegal flag present when LC3_DECODE_ILLEGAL_EN is defined.
interface lc3_decode_pipe_if #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 2
) ();
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       Imem_dout;
  logic [ADDR_W-1:0] npc_in;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       IR;
  logic [ADDR_W-1:0] npc_out;
  logic [5:0]        E_Control;
  logic [1:0]        W_Control;
  logic              Mem_Control;
  logic [CNT_W-1:0]  count;
`ifdef LC3_DECODE_ILLEGAL_EN
  logic              illegal;
`endif

  modport slave (
`ifdef LC3_DECODE_ILLEGAL_EN
    output illegal,
`endif
    input  in_valid, Imem_dout, npc_in, out_ready,
    output in_ready, out_valid, IR, npc_out,
    output E_Control, W_Control, Mem_Control, count
  );

  modport master (
`ifdef LC3_DECODE_ILLEGAL_EN
    input  illegal,
`endif
    output in_valid, Imem_dout, npc_in, out_ready,
    input  in_ready, out_valid, IR, npc_out,
    input  E_Control, W_Control, Mem_Control, count
  );
endinterface

// File: rtl/lc3_decode_pipe.sv
// lc3_decode_pipe: LC3 decode stage with a DEPTH-entry decoded FIFO.
// Define LC3_DECODE_ILLEGAL_EN to add the per-entry illegal flag.
module lc3_decode_pipe #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = $clog2(DEPTH+1)
) (
  input logic clk,
  input logic rst,
  input logic flush,
  lc3_decode_pipe_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
`ifdef LC3_DECODE_ILLEGAL_EN
  localparam int CTL_W = 10;
`else
  localparam int CTL_W = 9;
`endif
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [15:0]       r_ir_mem  [DEPTH];
  logic [ADDR_W-1:0] r_npc_mem [DEPTH];
  logic [CTL_W-1:0]  r_ctl_mem [DEPTH];

  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_valid;
  logic [15:0]       r_ir;
  logic [ADDR_W-1:0] r_npc;
  logic [CTL_W-1:0]  r_ctl;

  logic              w_in_ready;
  logic              w_push;
  logic              w_pop;
  logic [5:0]        w_e;
  logic [1:0]        w_w;
  logic              w_m;
  logic [CTL_W-1:0]  w_ctl;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [PTR_W-1:0]  w_rd_nxt;
  logic [15:0]       w_hd_ir;
  logic [ADDR_W-1:0] w_hd_npc;
  logic [CTL_W-1:0]  w_hd_ctl;
`ifdef LC3_DECODE_ILLEGAL_EN
  logic              w_ill;
`endif

  assign w_in_ready = (r_count < FULL);
  assign w_push = bus.in_valid & w_in_ready;
  assign w_pop  = r_valid & bus.out_ready;

  // Decode the incoming word into {alu, pcsel1, pcsel2, op2sel}, wb, mem.
  always_comb begin
    w_e = '0;
    w_w = '0;
    w_m = 1'b0;
`ifdef LC3_DECODE_ILLEGAL_EN
    w_ill = 1'b0;
`endif
    unique case (bus.Imem_dout[15:12])
      4'b0001: w_e = {5'b00000, ~bus.Imem_dout[5]};
      4'b0101: w_e = {5'b01000, ~bus.Imem_dout[5]};
      4'b1001: w_e = 6'b100000;
      4'b0000: w_e = 6'b000110;
      4'b1100: w_e = 6'b001100;
      4'b0100: begin
        w_e = bus.Imem_dout[11] ? 6'b000010 : 6'b001100;
        w_w = 2'b10;
      end
      4'b0010: begin
        w_e = 6'b000110;
        w_w = 2'b01;
      end
      4'b1010: begin
        w_e = 6'b000110;
        w_w = 2'b01;
        w_m = 1'b1;
      end
      4'b0110: begin
        w_e = 6'b001000;
        w_w = 2'b01;
      end
      4'b1110: begin
        w_e = 6'b000110;
        w_w = 2'b10;
      end
      4'b0011: w_e = 6'b000110;
      4'b1011: begin
        w_e = 6'b000110;
        w_m = 1'b1;
      end
      4'b0111: w_e = 6'b001000;
`ifdef LC3_DECODE_ILLEGAL_EN
      4'b1000, 4'b1101: w_ill = 1'b1;
`endif
      default: ;
    endcase
`ifdef LC3_DECODE_ILLEGAL_EN
    w_ctl = {w_ill, w_e, w_w, w_m};
`else
    w_ctl = {w_e, w_w, w_m};
`endif
  end

  // Pick the entry that will sit at the head after this edge.
  always_comb begin
    w_cnt_nxt = r_count;
    if (w_push && !w_pop) w_cnt_nxt = r_count + CNT_W'(1);
    if (!w_push && w_pop) w_cnt_nxt = r_count - CNT_W'(1);
    w_rd_nxt = w_pop ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;
    w_hd_ir  = r_ir_mem[w_rd_nxt];
    w_hd_npc = r_npc_mem[w_rd_nxt];
    w_hd_ctl = r_ctl_mem[w_rd_nxt];
    if (r_count == '0 || (w_pop && r_count == CNT_W'(1))) begin
      w_hd_ir  = bus.Imem_dout;
      w_hd_npc = bus.npc_in;
      w_hd_ctl = w_ctl;
    end
  end

  // Entry storage; only written entries are ever read back.
  always_ff @(posedge clk) begin
    if (rst && !flush && w_push) begin
      r_ir_mem[r_wr_ptr]  <= bus.Imem_dout;
      r_npc_mem[r_wr_ptr] <= bus.npc_in;
      r_ctl_mem[r_wr_ptr] <= w_ctl;
    end
  end

  // Pointers, occupancy and the registered head outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_ir     <= '0;
      r_npc    <= '0;
      r_ctl    <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_rd_ptr <= w_rd_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      r_count  <= w_cnt_nxt;
      r_valid  <= (w_cnt_nxt != '0);
      if (w_cnt_nxt != '0) begin
        r_ir  <= w_hd_ir;
        r_npc <= w_hd_npc;
        r_ctl <= w_hd_ctl;
      end
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = r_valid;
  assign bus.IR          = r_ir;
  assign bus.npc_out     = r_npc;
  assign bus.E_Control   = r_ctl[8:3];
  assign bus.W_Control   = r_ctl[2:1];
  assign bus.Mem_Control = r_ctl[0];
  assign bus.count       = r_count;
`ifdef LC3_DECODE_ILLEGAL_EN
  assign bus.illegal     = r_ctl[9];
`endif
endmodule
